// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2-D pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_EMIT     = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } pool_state_e;

    function automatic int pool_out_dim(input int in_dim, input int k, input int s);
        return (in_dim - k) / s + 1;
    endfunction

    // Counter width that never collapses to zero bits for a count of one.
    function automatic int pool_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_acc.sv
// Window accumulator: running signed max, or a widened sum shifted down by log2(K*K).
module pool_window_acc
    import pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int K      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_en,
    input  logic              init,
    input  logic              mode,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] result
);

    localparam int SH    = 2 * $clog2(K);
    localparam int SUM_W = DATA_W + SH;

    logic signed [DATA_W-1:0] din_s;
    logic signed [DATA_W-1:0] max_q, max_n;
    logic signed [SUM_W-1:0]  sum_q, sum_n;

    assign din_s = din;

    // result already includes the element presented this cycle, so the
    // top can register it on the very cycle the last window element lands.
    always_comb begin
        max_n = max_q;
        sum_n = sum_q;
        if (acc_en) begin
            if (init) begin
                max_n = din_s;
                sum_n = SUM_W'(din_s);
            end else begin
                if (din_s > max_q) max_n = din_s;
                sum_n = sum_q + SUM_W'(din_s);
            end
        end
        result = (mode == POOL_AVG) ? DATA_W'(sum_n >>> SH) : max_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q <= '0;
            sum_q <= '0;
        end else begin
            max_q <= max_n;
            sum_q <= sum_n;
        end
    end

endmodule

// File: rtl/pool_stream_engine.sv
// KxK / stride-S max or average pooling over CH channels, read from a 1-cycle
// latency feature buffer and emitted as a tagged valid/ready stream.
module pool_stream_engine
    import pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CH     = 32,
    parameter int IN_H   = 14,
    parameter int IN_W   = 14,
    parameter int K      = 2,
    parameter int S      = 2,
    localparam int OUT_H  = pool_out_dim(IN_H, K, S),
    localparam int OUT_W  = pool_out_dim(IN_W, K, S),
    localparam int ADDR_W = $clog2(CH * IN_H * IN_W),
    localparam int CH_W   = pool_w(CH),
    localparam int ROW_W  = pool_w(OUT_H),
    localparam int COL_W  = pool_w(OUT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic [2:0]        dbg_state
);

    localparam int KW = pool_w(K);
    localparam logic [KW-1:0]    K_LAST   = KW'(K - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

    if (K < 1 || (K & (K - 1)) != 0) begin : g_bad_k
        $error("pool_stream_engine: K must be a power of two");
    end
    if (S < 1) begin : g_bad_s
        $error("pool_stream_engine: S must be at least 1");
    end
    if (K > IN_H || K > IN_W) begin : g_bad_dim
        $error("pool_stream_engine: K exceeds input dimensions");
    end

    pool_state_e       state, state_n;
    logic              start_q, mode_q;
    logic [CH_W-1:0]   c;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [KW-1:0]     dy, dx;
    logic              rd_vld_q, first_q;
    logic [DATA_W-1:0] acc_result;
    logic [31:0]       win_y, win_x;
    logic              fetch_last, last_win, start_rise;

    assign fetch_last = (dy == K_LAST) && (dx == K_LAST);
    assign last_win   = (c == CH_LAST) && (row == ROW_LAST) && (col == COL_LAST);
    assign start_rise = start && !start_q;

    assign win_y   = 32'(row) * S + 32'(dy);
    assign win_x   = 32'(col) * S + 32'(dx);
    assign rd_addr = ADDR_W'((32'(c) * IN_H + win_y) * IN_W + win_x);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Stream handshake: out_valid rises in EMIT and holds with out_data and
    // tags frozen until a cycle where out_valid && out_ready; that cycle is
    // the transfer and the engine leaves EMIT on the following edge.
    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        dbg_state = state;
        case (state)
            ST_IDLE: begin
                if (start_rise) state_n = ST_FETCH;
            end
            ST_FETCH: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (fetch_last) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_n = ST_EMIT;
            end
            ST_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_n = last_win ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!start) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            mode_q   <= 1'b0;
            c        <= '0;
            row      <= '0;
            col      <= '0;
            dy       <= '0;
            dx       <= '0;
            rd_vld_q <= 1'b0;
            first_q  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else begin
            start_q  <= start;
            rd_vld_q <= (state == ST_FETCH);
            first_q  <= (state == ST_FETCH) && (dy == '0) && (dx == '0);
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        mode_q <= mode;
                        c      <= '0;
                        row    <= '0;
                        col    <= '0;
                        dy     <= '0;
                        dx     <= '0;
                    end
                end
                ST_FETCH: begin
                    if (dx == K_LAST) begin
                        dx <= '0;
                        dy <= (dy == K_LAST) ? '0 : dy + 1'b1;
                    end else begin
                        dx <= dx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    out_data <= acc_result;
                    out_ch   <= c;
                    out_row  <= row;
                    out_col  <= col;
                end
                ST_EMIT: begin
                    if (out_ready && !last_win) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row <= '0;
                                c   <= c + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    pool_window_acc #(
        .DATA_W(DATA_W),
        .K     (K)
    ) u_acc (
        .clk   (clk),
        .reset (reset),
        .acc_en(rd_vld_q),
        .init  (first_q),
        .mode  (mode_q),
        .din   (rd_data),
        .result(acc_result)
    );

endmodule

// File: tb/tb_pool_stream_engine.sv
// Bench for pool_stream_engine: three geometries (14x14x32 K2S2, 5x5x2 K2S2, 4x4x1 K2S1).
module tb_pool_stream_engine;
    import pool_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance a: default geometry
    logic start_a, mode_a, busy_a, done_a, rd_en_a, out_valid_a, out_ready_a;
    logic [12:0] rd_addr_a;
    logic [31:0] rd_data_a, out_data_a;
    logic [4:0]  out_ch_a;
    logic [2:0]  out_row_a, out_col_a, dbg_state_a;
    // instance b: 5x5, 2 channels, odd remainder row/col
    logic start_b, mode_b, busy_b, done_b, rd_en_b, out_valid_b, out_ready_b;
    logic [5:0]  rd_addr_b;
    logic [31:0] rd_data_b, out_data_b;
    logic [0:0]  out_ch_b, out_row_b, out_col_b;
    logic [2:0]  dbg_state_b;
    // instance s: 4x4, 1 channel, stride 1
    logic start_s, mode_s, busy_s, done_s, rd_en_s, out_valid_s, out_ready_s;
    logic [3:0]  rd_addr_s;
    logic [31:0] rd_data_s, out_data_s;
    logic [0:0]  out_ch_s;
    logic [1:0]  out_row_s, out_col_s;
    logic [2:0]  dbg_state_s;

    logic signed [31:0] mem_a [0:6271];
    logic signed [31:0] mem_b [0:49];
    logic signed [31:0] mem_s [0:15];

    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [63:0] exp_s[$];

    int rx [3];
    int done_cnt [3];
    logic signed [31:0] first_d [3];
    logic signed [31:0] second_d [3];
    int bad_b = 0;

    pool_stream_engine u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_ch(out_ch_a), .out_row(out_row_a),
        .out_col(out_col_a), .dbg_state(dbg_state_a)
    );

    pool_stream_engine #(.DATA_W(32), .CH(2), .IN_H(5), .IN_W(5), .K(2), .S(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_ch(out_ch_b), .out_row(out_row_b),
        .out_col(out_col_b), .dbg_state(dbg_state_b)
    );

    pool_stream_engine #(.DATA_W(32), .CH(1), .IN_H(4), .IN_W(4), .K(2), .S(1)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .mode(mode_s), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .out_data(out_data_s), .out_ch(out_ch_s), .out_row(out_row_s),
        .out_col(out_col_s), .dbg_state(dbg_state_s)
    );

    // feature buffers with one cycle read latency
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
        if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];
    end

    typedef struct {
        logic               mode;
        logic signed [31:0] w0, w1, w2, w3;
        logic signed [31:0] exp;
    } vec_t;
    vec_t vecs [9];

    function automatic logic [63:0] pack(input int ch, input int row, input int col, input logic [31:0] d);
        logic [15:0] c16;
        logic [7:0]  r8, k8;
        c16 = ch[15:0];
        r8  = row[7:0];
        k8  = col[7:0];
        return {c16, r8, k8, d};
    endfunction

    function automatic logic signed [31:0] pool4(input logic m, input logic signed [31:0] a, b, c, d);
        longint s;
        logic signed [31:0] mx;
        if (m) begin
            s = longint'(a) + longint'(b) + longint'(c) + longint'(d);
            s = s >>> 2;
            return 32'(s);
        end
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
        if (d > mx) mx = d;
        return mx;
    endfunction

    function automatic logic signed [31:0] memrd(input int inst, input int addr);
        case (inst)
            0:       return mem_a[addr];
            1:       return mem_b[addr];
            default: return mem_s[addr];
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic take(input int inst, input logic [63:0] act);
        logic [63:0] e;
        bit have;
        have = 0;
        e = '0;
        case (inst)
            0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1; end
            1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1; end
            default: if (exp_s.size() > 0) begin e = exp_s.pop_front(); have = 1; end
        endcase
        if (rx[inst] == 0) first_d[inst] = act[31:0];
        if (rx[inst] == 1) second_d[inst] = act[31:0];
        rx[inst]++;
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL out%0d_extra: got %0h with nothing expected", inst, act);
        end else if (act !== e) begin
            errors++;
            $display("FAIL out%0d_item: got %0h expected %0h", inst, act, e);
        end
    endtask

    task automatic sample();
        int a;
        if (out_valid_a && out_ready_a)
            take(0, pack(int'(out_ch_a), int'(out_row_a), int'(out_col_a), out_data_a));
        if (out_valid_b && out_ready_b)
            take(1, pack(int'(out_ch_b), int'(out_row_b), int'(out_col_b), out_data_b));
        if (out_valid_s && out_ready_s)
            take(2, pack(int'(out_ch_s), int'(out_row_s), int'(out_col_s), out_data_s));
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
        if (done_s) done_cnt[2]++;
        if (rd_en_b) begin
            a = int'(rd_addr_b);
            if (a >= 50 || ((a % 25) / 5) == 4 || (a % 5) == 4) bad_b++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int inst, input logic m);
        int nch, ih, iw, oh, ow, st, base;
        logic signed [31:0] v;
        case (inst)
            0:       begin nch = 32; ih = 14; iw = 14; oh = 7; ow = 7; st = 2; end
            1:       begin nch = 2;  ih = 5;  iw = 5;  oh = 2; ow = 2; st = 2; end
            default: begin nch = 1;  ih = 4;  iw = 4;  oh = 3; ow = 3; st = 1; end
        endcase
        for (int ch = 0; ch < nch; ch++)
            for (int r = 0; r < oh; r++)
                for (int cl = 0; cl < ow; cl++) begin
                    base = (ch * ih + r * st) * iw + cl * st;
                    v = pool4(m, memrd(inst, base), memrd(inst, base + 1),
                              memrd(inst, base + iw), memrd(inst, base + iw + 1));
                    case (inst)
                        0:       exp_a.push_back(pack(ch, r, cl, v));
                        1:       exp_b.push_back(pack(ch, r, cl, v));
                        default: exp_s.push_back(pack(ch, r, cl, v));
                    endcase
                end
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0:       start_a = v;
            1:       start_b = v;
            default: start_s = v;
        endcase
    endtask

    task automatic set_mode(input int inst, input logic v);
        case (inst)
            0:       mode_a = v;
            1:       mode_b = v;
            default: mode_s = v;
        endcase
    endtask

    // One full run; mode is flipped a few cycles in, which must not matter.
    task automatic run(input int inst, input logic m, input int budget, input bit drop);
        int n, d0;
        d0 = done_cnt[inst];
        rx[inst] = 0;
        n = 0;
        set_mode(inst, m);
        set_start(inst, 1'b1);
        while (done_cnt[inst] == d0 && n < budget) begin
            cyc();
            n++;
            if (n == 3) set_mode(inst, ~m);
        end
        check($sformatf("run%0d_done", inst), 64'(done_cnt[inst] - d0), 64'd1);
        if (drop) begin
            set_start(inst, 1'b0);
            cyc();
            cyc();
        end
    endtask

    initial begin
        logic [34:0] snap;
        int n, d0, busy_seen;

        reset = 1'b1;
        start_a = 0; start_b = 0; start_s = 0;
        mode_a = 0;  mode_b = 0;  mode_s = 0;
        out_ready_a = 1; out_ready_b = 1; out_ready_s = 1;
        for (int i = 0; i < 3; i++) begin
            rx[i] = 0;
            done_cnt[i] = 0;
        end
        for (int i = 0; i < 6272; i++) mem_a[i] = i;
        for (int i = 0; i < 50; i++)   mem_b[i] = i * 3 - 70;
        for (int i = 0; i < 16; i++)   mem_s[i] = ((i * 37) % 23) - 11;

        vecs[0] = '{1'b1, 1, 2, 3, 5, 2};
        vecs[1] = '{1'b1, -1, -2, -3, -5, -3};
        vecs[2] = '{1'b0, -7, -3, -9, -4, -3};
        vecs[3] = '{1'b0, 5, 5, 5, 5, 5};
        vecs[4] = '{1'b1, 5, 5, 5, 5, 5};
        vecs[5] = '{1'b0, 32'sh80000000, 32'sh7fffffff, 0, -1, 32'sh7fffffff};
        vecs[6] = '{1'b1, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff};
        vecs[7] = '{1'b1, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
        vecs[8] = '{1'b1, -1, 0, 0, 0, -1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a", {busy_a, done_a, rd_en_a, out_valid_a, rd_addr_a, out_data_a,
                        out_ch_a, out_row_a, out_col_a, dbg_state_a}, 64'd0);
        check("rst_b", {busy_b, done_b, rd_en_b, out_valid_b, rd_addr_b, out_data_b}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc();

        // full default-geometry MAX run over input = address
        push_exp(0, 1'b0);
        run(0, 1'b0, 12000, 1);
        check("a_count", 64'(rx[0]), 64'd1568);
        check("a_first", 64'(first_d[0]), 64'd15);
        check("a_second", 64'(second_d[0]), 64'd17);
        check("a_done_once", 64'(done_cnt[0]), 64'd1);
        check("a_q_empty", 64'(exp_a.size()), 64'd0);

        // hand-computed windows at (0,0,0) on the 5x5 instance
        for (int i = 0; i < 9; i++) begin
            mem_b[0] = vecs[i].w0;
            mem_b[1] = vecs[i].w1;
            mem_b[5] = vecs[i].w2;
            mem_b[6] = vecs[i].w3;
            push_exp(1, vecs[i].mode);
            run(1, vecs[i].mode, 500, 1);
            check($sformatf("vec%0d", i), 64'(first_d[1]), 64'(vecs[i].exp));
            check($sformatf("vec%0d_count", i), 64'(rx[1]), 64'd8);
        end
        check("b_q_empty", 64'(exp_b.size()), 64'd0);

        // stride-1 geometry, both modes
        push_exp(2, 1'b0);
        run(2, 1'b0, 500, 1);
        check("s_max_count", 64'(rx[2]), 64'd9);
        push_exp(2, 1'b1);
        run(2, 1'b1, 500, 1);
        check("s_avg_count", 64'(rx[2]), 64'd9);
        check("s_q_empty", 64'(exp_s.size()), 64'd0);

        // downstream stall of 10 cycles mid-run
        push_exp(1, 1'b0);
        rx[1] = 0;
        d0 = done_cnt[1];
        mode_b = 1'b0;
        start_b = 1'b1;
        n = 0;
        while (rx[1] < 3 && n < 200) begin cyc(); n++; end
        out_ready_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 50) begin cyc(); n++; end
        check("stall_valid", 64'(out_valid_b), 64'd1);
        snap = {out_ch_b, out_row_b, out_col_b, out_data_b};
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("stall_hold%0d", i), {out_valid_b, rd_en_b, out_ch_b, out_row_b, out_col_b, out_data_b},
                  {1'b1, 1'b0, snap});
        end
        out_ready_b = 1'b1;
        n = 0;
        while (done_cnt[1] == d0 && n < 300) begin cyc(); n++; end
        check("stall_done", 64'(done_cnt[1] - d0), 64'd1);
        check("stall_count", 64'(rx[1]), 64'd8);
        start_b = 1'b0;
        cyc();
        cyc();

        // start held high past done must not retrigger
        push_exp(1, 1'b1);
        d0 = done_cnt[1];
        run(1, 1'b1, 500, 0);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (busy_b || rd_en_b) busy_seen++;
        end
        check("hold_no_rerun", 64'(busy_seen), 64'd0);
        check("hold_done_once", 64'(done_cnt[1] - d0), 64'd1);
        check("hold_state", 64'(dbg_state_b), 64'(ST_WAIT_LOW));
        start_b = 1'b0;
        cyc();
        cyc();
        check("hold_idle", 64'(dbg_state_b), 64'(ST_IDLE));

        // reset in the middle of a fetch, then a clean restart
        start_b = 1'b1;
        n = 0;
        while (!rd_en_b && n < 20) begin cyc(); n++; end
        cyc();
        reset = 1'b1;
        @(negedge clk);
        check("midrst", {busy_b, out_valid_b, rd_en_b, done_b, dbg_state_b}, 64'd0);
        start_b = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_b.delete();
        cyc();
        push_exp(1, 1'b0);
        run(1, 1'b0, 500, 1);
        check("restart_count", 64'(rx[1]), 64'd8);
        check("restart_q_empty", 64'(exp_b.size()), 64'd0);

        check("b_no_tail_reads", 64'(bad_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
